// File: rtl/ov7670_stream_gen.sv
// ============================================================================
// Module      : ov7670_stream_gen
// Description : Synthetic OV7670 transmitter. Emits VSYNC/HREF/PCLK/D with
//               camera timing, RGB565 at two bytes per pixel, from internally
//               generated test patterns.
// Ports       : clk        - system clock
//               rst        - synchronous reset, active low
//               enable     - run frames back to back while high
//               mode       - 0 colour bars, 1 ramp, 2 solid, 3 checkerboard
//               color_in   - RGB565 colour for solid mode
//               PCLK       - pixel clock, clk/2
//               VSYNC      - vertical sync, active high
//               HREF       - high during the active bytes of a line
//               D          - pixel byte (00 outside HREF)
//               busy       - high from frame start until frame_done
//               frame_done - one-clk pulse on the last tick of a frame
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_stream_gen #(
  parameter int CAM_SCREEN_X = 320,
  parameter int CAM_SCREEN_Y = 240,
  parameter int VSYNC_LINES  = 3,
  parameter int VBP_LINES    = 17,
  parameter int VFP_LINES    = 10,
  parameter int HBLANK_TICKS = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] color_in,
  output logic        PCLK,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        busy,
  output logic        frame_done
);

  localparam int LINE_TICKS = 2 * CAM_SCREEN_X + HBLANK_TICKS;
  localparam int TW    = $clog2(LINE_TICKS);
  localparam int XW    = ($clog2(CAM_SCREEN_X) > 9) ? $clog2(CAM_SCREEN_X) : 9;
  localparam int YW    = ($clog2(CAM_SCREEN_Y) > 5) ? $clog2(CAM_SCREEN_Y) : 5;
  localparam int LW    = $clog2(VSYNC_LINES + VBP_LINES + CAM_SCREEN_Y + VFP_LINES + 1);
  localparam int BAR_W = CAM_SCREEN_X / 8;
  localparam int BW    = $clog2(BAR_W);

  localparam logic [TW-1:0] TICK_LAST  = TW'(LINE_TICKS - 1);
  localparam logic [TW-1:0] ACT_TICKS  = TW'(2 * CAM_SCREEN_X);
  localparam logic [XW-1:0] X_LAST     = XW'(CAM_SCREEN_X - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(CAM_SCREEN_Y - 1);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);
  localparam logic [LW-1:0] VS_LAST    = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST   = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] ACT_LAST   = LW'(CAM_SCREEN_Y - 1);
  localparam logic [LW-1:0] VFP_LAST   = LW'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBP    = 3'd2,
    S_ACTIVE = 3'd3,
    S_VFP    = 3'd4
  } state_t;

  // tick/line/x/y/bar describe the next tick to be emitted, not the one
  // currently on the outputs.
  state_t          state;
  logic [TW-1:0]   tick;
  logic [LW-1:0]   line;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BW-1:0]   bar_sub;
  logic [2:0]      bar_idx;
  logic [1:0]      mode_q;
  logic [15:0]     color_q;

  logic            seg_last_line;
  logic            in_href;
  logic [15:0]     pixel;
  logic [8:0]      x9;
  logic            unused_bits;

  assign x9          = x[8:0];
  assign in_href     = (state == S_ACTIVE) && (tick < ACT_TICKS);
  assign unused_bits = ^{x, y};

  always_comb begin
    seg_last_line = 1'b0;
    case (state)
      S_VSYNC:  seg_last_line = (line == VS_LAST);
      S_VBP:    seg_last_line = (line == VBP_LAST);
      S_ACTIVE: seg_last_line = (line == ACT_LAST);
      S_VFP:    seg_last_line = (line == VFP_LAST);
      default:  seg_last_line = 1'b0;
    endcase
  end

  always_comb begin
    pixel = 16'h0000;
    case (mode_q)
      2'd0: begin
        case (bar_idx)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {x9[8:4], x9[8:3], x9[8:4]};
      2'd2:    pixel = color_q;
      default: pixel = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      PCLK       <= 1'b0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      state      <= S_IDLE;
      tick       <= '0;
      line       <= '0;
      x          <= '0;
      y          <= '0;
      bar_sub    <= '0;
      bar_idx    <= 3'd0;
      mode_q     <= 2'd0;
      color_q    <= 16'h0000;
    end else begin
      PCLK       <= ~PCLK;
      frame_done <= 1'b0;
      // PCLK currently high means this edge is its falling edge
      if (PCLK) begin
        if (state == S_IDLE) begin
          VSYNC   <= 1'b0;
          HREF    <= 1'b0;
          D       <= 8'h00;
          tick    <= '0;
          line    <= '0;
          x       <= '0;
          y       <= '0;
          bar_sub <= '0;
          bar_idx <= 3'd0;
          if (enable) begin
            // tick 0 of the frame goes out now; continue from tick 1
            mode_q  <= mode;
            color_q <= color_in;
            busy    <= 1'b1;
            VSYNC   <= 1'b1;
            tick    <= TW'(1);
            state   <= S_VSYNC;
          end
        end else begin
          VSYNC <= (state == S_VSYNC);
          HREF  <= in_href;
          D     <= in_href ? (tick[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;

          if (in_href && tick[0]) begin
            if (x == X_LAST) begin
              x       <= '0;
              bar_sub <= '0;
              bar_idx <= 3'd0;
            end else begin
              x <= x + 1'b1;
              if (bar_sub == BAR_LAST) begin
                bar_sub <= '0;
                bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_sub <= bar_sub + 1'b1;
              end
            end
          end

          if (tick == TICK_LAST) begin
            tick <= '0;
            if (state == S_ACTIVE)
              y <= (y == Y_LAST) ? '0 : y + 1'b1;
            if (seg_last_line) begin
              line <= '0;
              case (state)
                S_VSYNC:  state <= S_VBP;
                S_VBP:    state <= S_ACTIVE;
                S_ACTIVE: state <= S_VFP;
                default: begin
                  // last tick of the frame is being emitted on this edge
                  state      <= S_IDLE;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                end
              endcase
            end else begin
              line <= line + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
// ============================================================================
// Module      : tb_ov7670_stream_gen
// Description : Self-checking bench for ov7670_stream_gen with a reduced
//               geometry. A per-clock reference stream is queued at each
//               rising clk edge and compared at the following falling edge;
//               a small receiver captures each frame for image checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov7670_stream_gen;

  localparam int X   = 64;
  localparam int Y   = 20;
  localparam int VS  = 1;
  localparam int VBP = 2;
  localparam int VFP = 1;
  localparam int HB  = 4;
  localparam int LT  = 2 * X + HB;
  localparam int FRAME_TICKS = (VS + VBP + Y + VFP) * LT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] color_in = 16'h0000;
  logic        PCLK, VSYNC, HREF, busy, frame_done;
  logic [7:0]  D;

  ov7670_stream_gen #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .VSYNC_LINES(VS),
    .VBP_LINES(VBP), .VFP_LINES(VFP), .HBLANK_TICKS(HB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .color_in(color_in),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          frm;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[$];

  // reference model state
  bit          m_ph = 1'b0;
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [1:0]  m_md = 2'd0;
  logic [15:0] m_col = 16'h0;
  logic [9:0]  m_vhd = 10'h0;
  bit          m_busy = 1'b0;
  logic [12:0] exp_q[$];

  // receiver / statistics
  logic [15:0] img [0:Y-1][0:X-1];
  int          row = 0, col = 0;
  bit          bph = 1'b0, in_line = 1'b0, href_prev = 1'b0;
  logic [7:0]  hi = 8'h00;
  int          cyc = 0, vclks = 0, hclks = 0, hpulses = 0;

  function automatic logic [15:0] bar_color(int b);
    case (b)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // {VSYNC, HREF, D} for tick t of a frame
  function automatic logic [9:0] exp_vhd(int t, logic [1:0] md, logic [15:0] c);
    int ln, tk, al, px;
    logic [8:0]  x9;
    logic [31:0] alv;
    logic [15:0] pix;
    ln = t / LT;
    tk = t % LT;
    al = ln - VS - VBP;
    if (ln < VS) return {1'b1, 1'b0, 8'h00};
    if (al < 0 || al >= Y || tk >= 2 * X) return 10'h000;
    px  = tk / 2;
    x9  = px[8:0];
    alv = al;
    case (md)
      2'd0:    pix = bar_color(px / (X / 8));
      2'd1:    pix = {x9[8:4], x9[8:3], x9[8:4]};
      2'd2:    pix = c;
      default: pix = (x9[4] ^ alv[4]) ? 16'hFFFF : 16'h0000;
    endcase
    return {1'b0, 1'b1, (tk % 2 == 0) ? pix[15:8] : pix[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_update();
    bit fall, done;
    done = 1'b0;
    if (!rst) begin
      m_ph = 1'b0; m_run = 1'b0; m_t = 0; m_vhd = 10'h0; m_busy = 1'b0;
    end else begin
      fall = m_ph;
      m_ph = !m_ph;
      if (fall) begin
        if (m_run && m_t != FRAME_TICKS - 1) m_t++;
        else if (enable) begin
          m_run = 1'b1; m_t = 0; m_md = mode; m_col = color_in;
        end else m_run = 1'b0;
        if (m_run) begin
          m_vhd  = exp_vhd(m_t, m_md, m_col);
          done   = (m_t == FRAME_TICKS - 1);
          m_busy = !done;
        end else begin
          m_vhd = 10'h0; m_busy = 1'b0;
        end
      end
    end
    exp_q.push_back({m_ph, m_vhd, m_busy, done});
  endtask

  task automatic monitor();
    logic [12:0] e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("stream", {19'h0, PCLK, VSYNC, HREF, D, busy, frame_done}, {19'h0, e});
    end
    if (VSYNC) vclks++;
    if (HREF) hclks++;
    if (HREF && !href_prev) hpulses++;
    href_prev = HREF;
    if (PCLK) begin
      if (VSYNC) begin row = 0; col = 0; bph = 1'b0; in_line = 1'b0; end
      if (HREF) begin
        in_line = 1'b1;
        if (!bph) hi = D;
        else begin
          if (row < Y && col < X) img[row][col] = {hi, D};
          col++;
        end
        bph = !bph;
      end else if (in_line) begin
        in_line = 1'b0; row++; col = 0; bph = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (frame_done) return;
    end
    checks++;
    errors++;
    $display("FAIL frame_done_timeout actual=none required=pulse within %0d clk", limit);
  endtask

  task automatic check_img(input int f);
    foreach (vt[i])
      if (vt[i].frm == f)
        check($sformatf("img_f%0d_x%0d_y%0d", f, vt[i].x, vt[i].y),
              {16'h0, img[vt[i].y][vt[i].x]}, {16'h0, vt[i].exp});
  endtask

  function automatic void add(int f, int xx, int yy, logic [15:0] e);
    vec_t v;
    v.frm = f; v.x = xx; v.y = yy; v.exp = e;
    vt.push_back(v);
  endfunction

  initial begin
    int tA, tB, vb, hb, pb, extra;
    bit started;

    // frame 0: colour bars (8 px wide)
    add(0, 0, 0, 16'hFFFF);  add(0, 8, 0, 16'hFFE0);  add(0, 16, 0, 16'h07FF);
    add(0, 24, 3, 16'h07E0); add(0, 32, 3, 16'hF81F); add(0, 40, 0, 16'hF800);
    add(0, 50, 10, 16'h001F); add(0, 63, 0, 16'h0000); add(0, 7, 19, 16'hFFFF);
    // frame 1: ramp
    add(1, 0, 2, 16'h0000);  add(1, 8, 2, 16'h0020);
    add(1, 16, 2, 16'h0841); add(1, 63, 2, 16'h18E3);
    // frames 2/3: solid colour latched per frame
    add(2, 0, 0, 16'h1234);  add(2, 63, 19, 16'h1234); add(2, 31, 7, 16'h1234);
    add(3, 0, 0, 16'hABCD);  add(3, 40, 12, 16'hABCD);
    // frame 4: checkerboard, 16x16 squares
    add(4, 0, 0, 16'h0000);  add(4, 16, 0, 16'hFFFF);  add(4, 16, 16, 16'h0000);
    add(4, 0, 16, 16'hFFFF); add(4, 20, 3, 16'hFFFF);  add(4, 40, 5, 16'h0000);

    rst = 1'b0;
    repeat (3) step();
    check("reset_outputs", {19'h0, PCLK, VSYNC, HREF, D, busy, frame_done}, 32'h0);

    enable = 1'b1; mode = 2'd0; rst = 1'b1;
    repeat (3000) step();
    mode = 2'd1;
    wait_done(8000);
    tA = cyc;
    check("vsync_clks", vclks, 2 * LT * VS);
    check("href_pulses", hpulses, Y);
    check("href_clks", hclks, Y * 4 * X);
    check_img(0);

    repeat (3000) step();
    mode = 2'd2; color_in = 16'h1234;
    wait_done(8000);
    tB = cyc;
    check("frame_period", tB - tA, 2 * FRAME_TICKS);
    check_img(1);

    repeat (3000) step();
    color_in = 16'hABCD;
    wait_done(8000);
    check_img(2);

    repeat (3000) step();
    mode = 2'd3;
    wait_done(8000);
    check_img(3);

    repeat (10 * 2 * LT) step();
    enable = 1'b0;
    wait_done(8000);
    check_img(4);
    extra = 0;
    repeat (300) begin
      step();
      if (frame_done) extra++;
    end
    check("idle_busy", busy, 0);
    check("idle_vsync", VSYNC, 0);
    check("idle_extra_done", extra, 0);

    enable = 1'b1;
    started = 1'b0;
    repeat (2) begin
      step();
      if (VSYNC) started = 1'b1;
    end
    check("restart_within_2clk", started, 1);

    repeat (12 * 2 * LT) step();
    rst = 1'b0;
    step();
    check("midframe_reset_outputs", {19'h0, PCLK, VSYNC, HREF, D, busy, frame_done}, 32'h0);
    rst = 1'b1;
    vb = vclks; hb = hclks; pb = hpulses;
    wait_done(8000);
    check("restart_vsync_clks", vclks - vb, 2 * LT * VS);
    check("restart_href_pulses", hpulses - pb, Y);
    check("restart_href_clks", hclks - hb, Y * 4 * X);
    check_img(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
